// File: rtl/colour_gen_lfsr_param.sv
// colour_gen_lfsr_param
//   RGB colour stream from a seedable Galois LFSR with a valid/ready output
//   handshake, four colour modes and an accepted-colour counter.
//
// Optional build macro: MIN_BRIGHT_EN
//   When defined, generated candidates in modes 00/01/10 whose r+g+b is below
//   MIN_SUM are discarded and the LFSR steps again on the next cycle.
//
// Ports
//   clk          in   clock, all logic on posedge
//   reset        in   synchronous active-low reset
//   en           in   generation enable
//   mode         in   00 random, 01 grey, 10 pastel, 11 complement-alternate
//   seed_load    in   load seed_in into the LFSR (priority over all but reset)
//   seed_in      in   new seed; zero maps to the default seed
//   out_ready    in   consumer ready
//   out_valid    out  colour valid
//   r, g, b      out  colour channels
//   sample_count out  number of accepted colours, wraps
module colour_gen_lfsr_param #(
  parameter int unsigned           CH_W    = 8,
  parameter int unsigned           LFSR_W  = 32,
  parameter logic [LFSR_W-1:0]     TAPS    = 32'h80200003,
  parameter logic [LFSR_W-1:0]     SEED    = 32'h00000001,
  parameter int unsigned           CNT_W   = 16,
  parameter logic [CH_W+1:0]       MIN_SUM = 10'h030
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CH_W-1:0]   r,
  output logic [CH_W-1:0]   g,
  output logic [CH_W-1:0]   b,
  output logic [CNT_W-1:0]  sample_count
);

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SeedEff =
      (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic              toggle_q;

  logic [LFSR_W-1:0] nxt;
  logic [CH_W-1:0]   sl_r, sl_g, sl_b;
  logic [CH_W-1:0]   cand_r, cand_g, cand_b;
  logic              accept;
  logic              gen;
  logic              do_comp;
  logic              reject;

  always_comb begin
    nxt  = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    sl_r = nxt[3*CH_W-1:2*CH_W];
    sl_g = nxt[2*CH_W-1:CH_W];
    sl_b = nxt[CH_W-1:0];

    cand_r = sl_r;
    cand_g = sl_g;
    cand_b = sl_b;
    unique case (mode)
      2'b01: begin
        cand_g = sl_r;
        cand_b = sl_r;
      end
      2'b10: begin
        cand_r = {1'b1, sl_r[CH_W-1:1]};
        cand_g = {1'b1, sl_g[CH_W-1:1]};
        cand_b = {1'b1, sl_b[CH_W-1:1]};
      end
      default: ;
    endcase

    accept = out_valid & out_ready;
    // A new colour may be produced when nothing is presented or the
    // presented one is being taken this cycle.
    gen    = en & (~out_valid | out_ready);
    // Complement only replaces a colour that is actually presented.
    do_comp = (mode == 2'b11) & toggle_q & out_valid;
  end

`ifdef MIN_BRIGHT_EN
  logic [CH_W+1:0] cand_sum;
  always_comb begin
    cand_sum = {2'b00, cand_r} + {2'b00, cand_g} + {2'b00, cand_b};
    reject   = (mode != 2'b11) & (cand_sum < MIN_SUM);
  end
`else
  logic unused_min_sum;
  assign unused_min_sum = ^MIN_SUM;
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q       <= SeedEff;
      toggle_q     <= 1'b0;
      out_valid    <= 1'b0;
      r            <= '0;
      g            <= '0;
      b            <= '0;
      sample_count <= '0;
    end else begin
      if (accept) begin
        sample_count <= sample_count + 1'b1;
      end

      if (seed_load) begin
        lfsr_q    <= (seed_in == '0) ? SeedEff : seed_in;
        out_valid <= 1'b0;
        toggle_q  <= 1'b0;
      end else begin
        if (mode != 2'b11) begin
          toggle_q <= 1'b0;
        end

        if (gen) begin
          if (do_comp) begin
            r         <= ~r;
            g         <= ~g;
            b         <= ~b;
            out_valid <= 1'b1;
            toggle_q  <= 1'b0;
          end else if (reject) begin
            lfsr_q    <= nxt;
            out_valid <= 1'b0;
          end else begin
            lfsr_q    <= nxt;
            r         <= cand_r;
            g         <= cand_g;
            b         <= cand_b;
            out_valid <= 1'b1;
            if (mode == 2'b11) begin
              toggle_q <= 1'b1;
            end
          end
        end else if (accept) begin
          // Accepted with en low: drop valid, LFSR holds.
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_colour_gen_lfsr_param.sv
// Testbench for colour_gen_lfsr_param: directed vector table, hand sequence
// for the brightness filter, and randomized stimulus against a reference model.
module tb_colour_gen_lfsr_param;

  localparam logic [31:0] Taps = 32'h80200003;

  logic        clk;
  logic        reset;
  logic        en;
  logic [1:0]  mode;
  logic        seed_load;
  logic [31:0] seed_in;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  r, g, b;
  logic [15:0] sample_count;

  int nvec;
  int nerr;

  colour_gen_lfsr_param dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .mode         (mode),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .r            (r),
    .g            (g),
    .b            (b),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    bit          en;
    bit [1:0]    mode;
    bit          rdy;
    bit          sl;
    bit [31:0]   sin;
    bit          ev;
    bit [7:0]    er, eg, eb;
    int          ec;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst_n, bit e, bit [1:0] m, bit rdy, bit sl, bit [31:0] sin,
                              bit ev, bit [7:0] er, bit [7:0] eg, bit [7:0] eb, int ec);
    vec_t v;
    v.rst_n = rst_n; v.en = e; v.mode = m; v.rdy = rdy; v.sl = sl; v.sin = sin;
    v.ev = ev; v.er = er; v.eg = eg; v.eb = eb; v.ec = ec;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, bit ev, bit [7:0] er, bit [7:0] eg, bit [7:0] eb, int ec);
    nvec++;
    if (out_valid !== ev || r !== er || g !== eg || b !== eb || sample_count !== 16'(ec)) begin
      nerr++;
      $display("FAIL %s: got v=%0b rgb=(%02h,%02h,%02h) cnt=%0d, want v=%0b rgb=(%02h,%02h,%02h) cnt=%0d",
               name, out_valid, r, g, b, sample_count, ev, er, eg, eb, ec);
    end
  endtask

  task automatic drive_step(bit rst_n, bit e, bit [1:0] m, bit rdy, bit sl, bit [31:0] sin);
    reset = rst_n; en = e; mode = m; out_ready = rdy; seed_load = sl; seed_in = sin;
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks the presented colour and the generator state.
  logic [31:0] m_lfsr;
  bit          m_valid;
  bit          m_tog;
  int          m_r, m_g, m_b;
  int          m_cnt;

  function automatic logic [31:0] step32(logic [31:0] x);
    return (x >> 1) ^ ((x % 2 == 1) ? Taps : 32'h0);
  endfunction

  task automatic model(bit rst_n, bit e, bit [1:0] m, bit rdy, bit sl, bit [31:0] sin);
    bit took;
    int cr, cg, cb;
    if (!rst_n) begin
      m_lfsr = 32'd1; m_valid = 0; m_tog = 0; m_r = 0; m_g = 0; m_b = 0; m_cnt = 0;
      return;
    end
    took = m_valid && rdy;
    if (took) m_cnt = (m_cnt + 1) % 65536;
    if (sl) begin
      m_lfsr  = (sin == 0) ? 32'd1 : sin;
      m_valid = 0;
      m_tog   = 0;
      return;
    end
    if (m != 3) m_tog = 0;
    if (!e) begin
      if (took) m_valid = 0;
    end else if (m_valid && !rdy) begin
      // held by backpressure
    end else if (m == 3 && m_tog && m_valid) begin
      m_r = 255 - m_r; m_g = 255 - m_g; m_b = 255 - m_b;
      m_tog = 0;
      m_valid = 1;
    end else begin
      m_lfsr = step32(m_lfsr);
      cr = int'((m_lfsr / 65536) % 256);
      cg = int'((m_lfsr / 256) % 256);
      cb = int'(m_lfsr % 256);
      if (m == 1) begin
        cg = cr; cb = cr;
      end else if (m == 2) begin
        cr = 128 + cr / 2; cg = 128 + cg / 2; cb = 128 + cb / 2;
      end
`ifdef MIN_BRIGHT_EN
      if (m != 3 && (cr + cg + cb) < 48) begin
        m_valid = 0;
        return;
      end
`endif
      m_r = cr; m_g = cg; m_b = cb;
      m_valid = 1;
      if (m == 3) m_tog = 1;
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset = 0; en = 0; mode = 0; out_ready = 0; seed_load = 0; seed_in = 0;

`ifndef MIN_BRIGHT_EN
    // Basic stream, mode 00
    add(0, 0, 0, 0, 0, 0,            0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 1, 0, 1, 0, 0,            1, 8'h20, 8'h00, 8'h03, 0);
    add(1, 1, 0, 1, 0, 0,            1, 8'h30, 8'h00, 8'h02, 1);
    add(1, 1, 0, 1, 0, 0,            1, 8'h18, 8'h00, 8'h01, 2);
    add(1, 0, 0, 1, 0, 0,            0, 8'h18, 8'h00, 8'h01, 3);
    // Backpressure
    add(0, 0, 0, 0, 0, 0,            0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 1, 0, 0, 0, 0,            1, 8'h20, 8'h00, 8'h03, 0);
    for (int i = 0; i < 5; i++)
      add(1, 1, 0, 0, 0, 0,          1, 8'h20, 8'h00, 8'h03, 0);
    add(1, 1, 0, 1, 0, 0,            1, 8'h30, 8'h00, 8'h02, 1);
    // Grey and pastel
    add(0, 0, 0, 0, 0, 0,            0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 1, 1, 1, 0, 0,            1, 8'h20, 8'h20, 8'h20, 0);
    add(0, 0, 0, 0, 0, 0,            0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 1, 2, 1, 0, 0,            1, 8'h90, 8'h80, 8'h81, 0);
    // Complement-alternate
    add(0, 0, 0, 0, 0, 0,            0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 1, 3, 1, 0, 0,            1, 8'h20, 8'h00, 8'h03, 0);
    add(1, 1, 3, 1, 0, 0,            1, 8'hDF, 8'hFF, 8'hFC, 1);
    add(1, 1, 3, 1, 0, 0,            1, 8'h30, 8'h00, 8'h02, 2);
    add(1, 1, 3, 1, 0, 0,            1, 8'hCF, 8'hFF, 8'hFD, 3);
    // Seed loads: retract valid, count the accept, restart sequence
    add(1, 1, 0, 1, 1, 0,            0, 8'hCF, 8'hFF, 8'hFD, 4);
    add(1, 1, 0, 1, 0, 0,            1, 8'h20, 8'h00, 8'h03, 4);
    add(1, 1, 0, 1, 1, 32'h80200003, 0, 8'h20, 8'h00, 8'h03, 5);
    add(1, 1, 0, 1, 0, 0,            1, 8'h30, 8'h00, 8'h02, 5);
    // Reset mid-stream
    add(1, 1, 0, 1, 0, 0,            1, 8'h18, 8'h00, 8'h01, 6);
    add(0, 1, 0, 1, 0, 0,            0, 8'h00, 8'h00, 8'h00, 0);

    foreach (vecs[i]) begin
      drive_step(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].rdy, vecs[i].sl, vecs[i].sin);
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].eg, vecs[i].eb, vecs[i].ec);
    end
`else
    // Dim first candidate (sum 0x23) is dropped, next one (sum 0x32) passes.
    drive_step(0, 0, 0, 0, 0, 0);
    check("bright_reset", 0, 8'h00, 8'h00, 8'h00, 0);
    drive_step(1, 1, 0, 1, 0, 0);
    check("bright_reject", 0, 8'h00, 8'h00, 8'h00, 0);
    drive_step(1, 1, 0, 1, 0, 0);
    check("bright_pass", 1, 8'h30, 8'h00, 8'h02, 0);
`endif

    // Randomized stimulus against the reference model.
    model(0, 0, 0, 0, 0, 0);
    drive_step(0, 0, 0, 0, 0, 0);
    check("rand_reset", bit'(m_valid), 8'(m_r), 8'(m_g), 8'(m_b), m_cnt);
    begin
      bit [1:0] cur_mode;
      cur_mode = 0;
      for (int i = 0; i < 3000; i++) begin
        bit rn, e, rdy, sl;
        bit [31:0] sin;
        rn  = ($urandom_range(0, 299) != 0);
        e   = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 2) != 0);
        sl  = ($urandom_range(0, 63) == 0);
        sin = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
        if ($urandom_range(0, 15) == 0) cur_mode = 2'($urandom_range(0, 3));
        model(rn, e, cur_mode, rdy, sl, sin);
        drive_step(rn, e, cur_mode, rdy, sl, sin);
        check($sformatf("rand%0d", i), bit'(m_valid), 8'(m_r), 8'(m_g), 8'(m_b), m_cnt);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/colour_gen_lfsr_param.md
Name: colour_gen_lfsr_param

Overview:
Parametrised successor to the fixed 8-bit random colour generator. It produces a stream of RGB colours from a seedable Galois LFSR with a valid/ready output handshake and four colour modes (random, grey, pastel, complement-alternate), and keeps a count of accepted colours. It sits between the control logic and any pixel or LED consumer that pulls colours at its own rate.

Parameters:
- CH_W, 8, bits per colour channel.
- LFSR_W, 32, LFSR width. Must satisfy LFSR_W >= 3*CH_W.
- TAPS, 32'h80200003, Galois feedback mask (x^32+x^22+x^2+x+1).
- SEED, 32'h00000001, reset/default seed. If SEED==0, the value 1 is used instead.
- CNT_W, 16, width of sample_count.
- MIN_SUM, 10'h030, minimum r+g+b. Used only when MIN_BRIGHT_EN is defined.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk.
- en  in  1  generation enable.
- mode  in  2  00 random, 01 grey, 10 pastel, 11 complement-alternate.
- seed_load  in  1  load seed_in into the LFSR.
- seed_in  in  LFSR_W  new seed. Zero maps to SEED.
- out_ready  in  1  consumer ready.
- out_valid  out  1  colour valid.
- r, g, b  out  CH_W each  colour channels.
- sample_count  out  CNT_W  number of accepted colours (out_valid & out_ready), wraps.

Behaviour:
- Reset (reset==0 at posedge):
  - lfsr <= SEED (1 if SEED==0).
  - out_valid, r, g, b, sample_count, and the complement toggle all reset to 0.
- Step function: nxt = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
- Slices: R = nxt[3*CH_W-1:2*CH_W], G = nxt[2*CH_W-1:CH_W], B = nxt[CH_W-1:0].
- Generate event: happens when (out_valid==0 && en) or (out_valid && out_ready && en). On a generate event:
  - lfsr <= nxt.
  - Outputs are registered from the slices, according to the mode sampled that cycle.
  - out_valid <= 1.
  - Latency: 1 cycle from en to out_valid. Throughput: 1 colour per cycle while ready stays high.
- Mode mapping:
  - 00: r=R, g=G, b=B.
  - 01: r=g=b=R.
  - 10: each channel = {1'b1, slice[CH_W-1:1]}.
  - 11, toggle==0: generate as mode 00, then set toggle=1.
  - 11, toggle==1: on accept, r/g/b <= ~r/~g/~b, the LFSR does not step, toggle=0.
  - Leaving mode 11 clears toggle.
- Handshake rules:
  - While out_valid && !out_ready, r/g/b/out_valid hold and the LFSR holds.
  - Dropping en never retracts a presented colour. If an accept occurs with en==0, out_valid <= 0 and the LFSR holds.
- sample_count increments on every accept, including the cycle that loads a seed. It wraps from all-ones to 0.
- seed_load has priority over everything except reset:
  - lfsr <= (seed_in==0 ? SEED : seed_in).
  - out_valid <= 0; toggle <= 0.
  - Generation resumes on the next cycle if en==1.
  - This is the only case in which out_valid is retracted.
- Reset asserted mid-stream: all state returns to reset values on that edge and no partial colour is presented.
- The LFSR can never reach 0: no zero seed can be loaded, and the Galois step with nonzero TAPS preserves nonzero state.

Optional Feature:
MIN_BRIGHT_EN.
- Defined: a generated candidate (modes 00/01/10) whose r+g+b (CH_W+2 bit sum) is below MIN_SUM is discarded.
  - The LFSR steps again next cycle and out_valid stays or goes 0 until a candidate passes.
  - Each rejection adds one cycle of latency.
  - Mode 11 complement colours are exempt.
- Undefined: no filtering; MIN_SUM is ignored; latency is always 1 cycle.

Test Plan:
1. Defaults, reset low for 1 cycle, en=1, mode=00, out_ready=1 → three consecutive colours:
   - (20,00,03) on the 1st valid cycle.
   - then (30,00,02).
   - then (18,00,01).
   - sample_count reaches 3 after three accepts.
2. Backpressure: after the first colour, out_ready=0 for 5 cycles → r/g/b hold at (20,00,03), out_valid=1, sample_count unchanged. Then out_ready=1 → (30,00,02) on the next cycle.
3. Mode 01 from reset → first colour (20,20,20). Mode 10 from reset → (90,80,81).
4. Mode 11 from reset, out_ready=1 → colour sequence (20,00,03), (DF,FF,FC), (30,00,02), (CF,FF,FD).
5. seed_load=1 with seed_in=0 mid-stream → out_valid=0 the next cycle, then the sequence restarts at (20,00,03). seed_in=32'h80200003 → first colour (30,00,02).
6. With MIN_BRIGHT_EN defined, MIN_SUM=0x030, reset, en=1 → (20,00,03) (sum 0x23) is rejected and out_valid stays 0 for the 1st cycle. (30,00,02) (sum 0x32) is valid on the 2nd cycle.
